// File: rtl/mcyc_pkg.sv
// mcyc_pkg: shared state encoding, opcode/ALU/write-back codes and ALU select helper for mcyc_ctrl
package mcyc_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
    S_LUI, S_MEM_ADDR, S_MEM_WAIT, S_WB_LD, S_BRANCH, S_TRAP
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_IMM = 2'd1;
  localparam logic [1:0] WD_MEM = 2'd2;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;
  // Immediate ops carry imm bits in funct7, so bit 5 only selects SRA/SRAI on the shift-right funct3.
  function automatic logic [3:0] alu_sel(input logic is_r, input logic [2:0] f3, input logic f7_5);
    return {(is_r || f3 == F3_SRX) && f7_5, f3};
  endfunction
endpackage

// File: rtl/mcyc_wait_cnt.sv
// mcyc_wait_cnt: MEM_WAIT cycle counter with clear, enable and limit compare
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (MEM_ADDR)
//   en         : count one un-acked MEM_WAIT cycle
//   hit        : current MEM_WAIT cycle is the last one allowed (MAX-th)
module mcyc_wait_cnt #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign hit = cnt == 8'(MAX - 1);
endmodule

// File: rtl/mcyc_ctrl.sv
// mcyc_ctrl: multi-cycle RISC-V style control FSM with bounded memory wait and sticky trap
//   clk, rst_n                : clock, async active-low reset
//   opcode, funct3, funct7    : decoded instruction fields
//   zf, mem_ack               : ALU zero flag, data-memory completion strobe
//   PC_Write, IR_Write, Reg_Write, ALU_OP, rs2_imm_s, w_data_s, mem_rd, mem_wr, pc_s : datapath controls
//   illegal, state            : sticky trap flag, current state for debug
//   MCYC_BRANCH_EN            : define to enable the BRANCH state; otherwise branches trap and pc_s is 0
module mcyc_ctrl
  import mcyc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zf,
  input  logic       mem_ack,
  output logic       PC_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic [3:0] ALU_OP,
  output logic       rs2_imm_s,
  output logic [1:0] w_data_s,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       pc_s,
  output logic       illegal,
  output logic [3:0] state
);
  state_t cur, nxt, br_dest;
  logic [3:0] alu_q;
  logic imm_q, ld_q, hit;
  logic unused_f7;
  assign unused_f7 = ^{funct7[6], funct7[4:0]};
`ifdef MCYC_BRANCH_EN
  logic taken;
  assign taken = (funct3 == F3_BEQ && zf) || (funct3 == F3_BNE && !zf);
  assign br_dest = S_BRANCH;
`else
  logic unused_zf;
  assign unused_zf = zf;
  assign br_dest = S_TRAP;
`endif
  mcyc_wait_cnt #(.MAX(MEM_WAIT_MAX)) u_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cur == S_MEM_ADDR),
    .en   (cur == S_MEM_WAIT && !mem_ack),
    .hit  (hit)
  );
  // ALU select/B source are captured in EXEC so WB_ALU keeps driving them; load/store is latched at decode.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur   <= S_IDLE;
      alu_q <= ALU_ADD;
      imm_q <= 1'b0;
      ld_q  <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_EXEC_R || cur == S_EXEC_I) begin
        alu_q <= ALU_OP;
        imm_q <= rs2_imm_s;
      end
      if (cur == S_DECODE) ld_q <= opcode == OP_LOAD;
    end
  always_comb begin
    nxt       = cur;
    PC_Write  = 1'b0;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    ALU_OP    = ALU_ADD;
    rs2_imm_s = 1'b0;
    w_data_s  = WD_ALU;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    pc_s      = 1'b0;
    illegal   = 1'b0;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        IR_Write = 1'b1;
        PC_Write = 1'b1;
        nxt      = S_DECODE;
      end
      S_DECODE:
        nxt = opcode == OP_R ? S_EXEC_R :
              opcode == OP_I ? S_EXEC_I :
              opcode == OP_LUI ? S_LUI :
              (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM_ADDR :
              opcode == OP_BRANCH ? br_dest : S_TRAP;
      S_EXEC_R, S_EXEC_I: begin
        ALU_OP    = alu_sel(cur == S_EXEC_R, funct3, funct7[5]);
        rs2_imm_s = cur == S_EXEC_I;
        nxt       = S_WB_ALU;
      end
      S_WB_ALU: begin
        Reg_Write = 1'b1;
        ALU_OP    = alu_q;
        rs2_imm_s = imm_q;
        nxt       = S_FETCH;
      end
      S_LUI: begin
        Reg_Write = 1'b1;
        w_data_s  = WD_IMM;
        nxt       = S_FETCH;
      end
      S_MEM_ADDR: begin
        rs2_imm_s = 1'b1;
        nxt       = S_MEM_WAIT;
      end
      // An ack on the limit cycle takes priority over the timeout.
      S_MEM_WAIT: begin
        mem_rd = ld_q;
        mem_wr = !ld_q;
        nxt    = mem_ack ? (ld_q ? S_WB_LD : S_FETCH) : hit ? S_TRAP : S_MEM_WAIT;
      end
      S_WB_LD: begin
        Reg_Write = 1'b1;
        w_data_s  = WD_MEM;
        nxt       = S_FETCH;
      end
`ifdef MCYC_BRANCH_EN
      S_BRANCH: begin
        ALU_OP   = ALU_SUB;
        PC_Write = taken;
        pc_s     = taken;
        nxt      = S_FETCH;
      end
`endif
      S_TRAP: illegal = 1'b1;
      default: nxt = S_IDLE;
    endcase
  end
  assign state = cur;
endmodule

// File: tb/tb_mcyc_ctrl.sv
// tb_mcyc_ctrl: scoreboard bench for mcyc_ctrl; stimulus queues expected per-cycle outputs, monitor compares on negedge
module tb_mcyc_ctrl;
  localparam logic [3:0] IDLE = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, EXEC_I = 4, WB_ALU = 5;
  localparam logic [3:0] LUI = 6, MEM_ADDR = 7, MEM_WAIT = 8, WB_LD = 9, BRANCH = 10, TRAP = 11;
  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPLUI = 7'b0110111;
  localparam logic [6:0] OPLD = 7'b0000011, OPST = 7'b0100011, OPBR = 7'b1100011;
  typedef struct packed {
    logic [3:0] st;
    logic pw, iw, rw;
    logic [3:0] aop;
    logic imm;
    logic [1:0] wd;
    logic rd, wr, ps, ill;
  } exp_t;
  logic clk = 0, rst_n = 0, zf = 0, mem_ack = 0;
  logic [6:0] opcode = 0, funct7 = 0;
  logic [2:0] funct3 = 0;
  logic PC_Write, IR_Write, Reg_Write, rs2_imm_s, mem_rd, mem_wr, pc_s, illegal;
  logic [3:0] ALU_OP, state;
  logic [1:0] w_data_s;
  exp_t act, mon_e, q[$];
  int ids[$], nid = 0, mon_id, checks = 0, errors = 0;
  mcyc_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zf(zf), .mem_ack(mem_ack), .PC_Write(PC_Write), .IR_Write(IR_Write),
    .Reg_Write(Reg_Write), .ALU_OP(ALU_OP), .rs2_imm_s(rs2_imm_s), .w_data_s(w_data_s),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_s(pc_s), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  assign act = {state, PC_Write, IR_Write, Reg_Write, ALU_OP, rs2_imm_s, w_data_s, mem_rd, mem_wr, pc_s, illegal};
  always @(negedge clk)
    if (q.size() != 0) begin
      mon_e  = q.pop_front();
      mon_id = ids.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL vec%0d got %h want %h", mon_id, act, mon_e);
      end
    end
  function automatic exp_t mk(input logic [3:0] st, input logic pw, iw, rw, input logic [3:0] aop,
                              input logic imm, input logic [1:0] wd, input logic rd, wr, ps, ill);
    return {st, pw, iw, rw, aop, imm, wd, rd, wr, ps, ill};
  endfunction
  function automatic exp_t only(input logic [3:0] st);
    return mk(st, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0, 0, st == TRAP);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input exp_t e);
    q.push_back(e);
    ids.push_back(nid);
    nid++;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, b);
    end
  endtask
  task automatic reset_seq();
    tick();
    rst_n = 0;
    push(only(IDLE));
    tick();
    rst_n = 1;
    push(only(IDLE));
  endtask
  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    tick();
    opcode  = op;
    funct3  = f3;
    funct7  = f7;
    mem_ack = 0;
    push(mk(FETCH, 1, 1, 0, 4'd0, 0, 2'd0, 0, 0, 0, 0));
    tick();
    push(only(DECODE));
  endtask
  task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] ex, input logic [3:0] aop, input logic imm);
    fetch_decode(op, f3, f7);
    tick();
    push(mk(ex, 0, 0, 0, aop, imm, 2'd0, 0, 0, 0, 0));
    tick();
    push(mk(WB_ALU, 0, 0, 1, aop, imm, 2'd0, 0, 0, 0, 0));
  endtask
  // ack_at = MEM_WAIT cycle (1-based) carrying mem_ack; 0 means never acked.
  task automatic mem_instr(input logic ld, input int ack_at);
    fetch_decode(ld ? OPLD : OPST, 3'b010, 7'd0);
    tick();
    push(mk(MEM_ADDR, 0, 0, 0, 4'd0, 1, 2'd0, 0, 0, 0, 0));
    for (int i = 1; i <= 15; i++) begin
      tick();
      mem_ack = i == ack_at;
      push(mk(MEM_WAIT, 0, 0, 0, 4'd0, 0, 2'd0, ld, !ld, 0, 0));
      if (i == ack_at) break;
    end
    if (ack_at == 0) begin
      tick();
      push(only(TRAP));
    end else if (ld) begin
      tick();
      mem_ack = 0;
      push(mk(WB_LD, 0, 0, 1, 4'd0, 0, 2'd2, 0, 0, 0, 0));
    end
  endtask
`ifdef MCYC_BRANCH_EN
  task automatic br(input logic [2:0] f3, input logic z, input logic tk);
    fetch_decode(OPBR, f3, 7'd0);
    tick();
    zf = z;
    push(mk(BRANCH, tk, 0, 0, 4'b1000, 0, 2'd0, 0, 0, tk, 0));
  endtask
`endif
  initial begin
    reset_seq();
    alu_instr(OPR, 3'b000, 7'h00, EXEC_R, 4'b0000, 0);
    alu_instr(OPR, 3'b000, 7'h20, EXEC_R, 4'b1000, 0);
    alu_instr(OPR, 3'b101, 7'h20, EXEC_R, 4'b1101, 0);
    alu_instr(OPI, 3'b101, 7'h20, EXEC_I, 4'b1101, 1);
    alu_instr(OPI, 3'b000, 7'h20, EXEC_I, 4'b0000, 1);
    alu_instr(OPI, 3'b111, 7'h00, EXEC_I, 4'b0111, 1);
    fetch_decode(OPLUI, 3'b000, 7'd0);
    tick();
    push(mk(LUI, 0, 0, 1, 4'd0, 0, 2'd1, 0, 0, 0, 0));
    mem_instr(1, 3);
    mem_instr(0, 15);
    mem_instr(1, 1);
`ifdef MCYC_BRANCH_EN
    br(3'b000, 1, 1);
    br(3'b000, 0, 0);
    br(3'b001, 0, 1);
    br(3'b001, 1, 0);
    br(3'b100, 1, 0);
`else
    fetch_decode(OPBR, 3'b000, 7'd0);
    tick();
    zf = 1;
    push(only(TRAP));
    tick();
    push(only(TRAP));
    reset_seq();
`endif
    fetch_decode(OPST, 3'b010, 7'd0);
    tick();
    push(mk(MEM_ADDR, 0, 0, 0, 4'd0, 1, 2'd0, 0, 0, 0, 0));
    tick();
    push(mk(MEM_WAIT, 0, 0, 0, 4'd0, 0, 2'd0, 0, 1, 0, 0));
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rst_state", {28'd0, state}, {28'd0, IDLE});
    chk("rst_reg_write", {31'd0, Reg_Write}, 0);
    tick();
    push(only(IDLE));
    rst_n = 1;
    fetch_decode(7'b1111111, 3'b000, 7'd0);
    repeat (20) begin
      tick();
      push(only(TRAP));
    end
    reset_seq();
    mem_instr(1, 0);
    tick();
    push(only(TRAP));
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcyc_ctrl.md
MCYC_CTRL -- requirements
Module: mcyc_ctrl

Interface
REQ-001 Parameter: MEM_WAIT_MAX, default 15, maximum cycles MEM_WAIT holds before trapping (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 opcode  input  7  decoded instruction opcode from ID1.
REQ-005 funct3  input  3  decoded funct3.
REQ-006 funct7  input  7  decoded funct7.
REQ-007 zf  input  1  ALU zero flag, sampled in BRANCH.
REQ-008 mem_ack  input  1  data-memory completion strobe.
REQ-009 PC_Write  output  1  PC update enable.
REQ-010 IR_Write  output  1  instruction register load enable.
REQ-011 Reg_Write  output  1  register-file write enable.
REQ-012 ALU_OP  output  4  ALU operation select.
REQ-013 rs2_imm_s  output  1  ALU B select: 0 = reg B, 1 = imm32.
REQ-014 w_data_s  output  2  write-back select: 0 = ALU F, 1 = imm32, 2 = memory data.
REQ-015 mem_rd, mem_wr  output  1 each  memory read/write request.
REQ-016 pc_s  output  1  PC source: 0 = PC+4, 1 = branch target.
REQ-017 illegal  output  1  sticky trap flag.
REQ-018 state  output  4  current state, for SW debug display.

Function
REQ-019 States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, LUI, MEM_ADDR, MEM_WAIT, WB_LD, BRANCH, TRAP.
REQ-020 IDLE -> FETCH unconditionally after reset release.
REQ-021 FETCH: IR_Write=1, PC_Write=1, pc_s=0 for exactly one cycle; -> DECODE.
REQ-022 DECODE by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0110111 -> LUI; 0000011/0100011 -> MEM_ADDR; 1100011 -> BRANCH; other -> TRAP.
REQ-023 EXEC_R: ALU_OP={funct7[5],funct3}, rs2_imm_s=0; -> WB_ALU.
REQ-024 EXEC_I: ALU_OP={funct3==101 ? funct7[5] : 0, funct3}, rs2_imm_s=1; -> WB_ALU.
REQ-025 WB_ALU: Reg_Write=1, w_data_s=0, ALU_OP/rs2_imm_s held from prior state; -> FETCH.
REQ-026 LUI: Reg_Write=1, w_data_s=1; -> FETCH.
REQ-027 MEM_ADDR: ALU_OP=ADD, rs2_imm_s=1; -> MEM_WAIT; wait counter cleared.
REQ-028 MEM_WAIT: mem_rd (load) or mem_wr (store) held high until mem_ack sampled high; load -> WB_LD, store -> FETCH.
REQ-029 Wait counter increments each MEM_WAIT cycle without ack; reaching MEM_WAIT_MAX -> TRAP, request dropped same edge; ack on the limit cycle wins.
REQ-030 WB_LD: Reg_Write=1, w_data_s=2; -> FETCH.
REQ-031 BRANCH: ALU_OP=SUB, rs2_imm_s=0; taken (beq&zf, bne&!zf) -> PC_Write=1, pc_s=1; other funct3 not taken; -> FETCH.
REQ-032 TRAP: illegal=1, all enables 0, held until reset.
REQ-033 Outputs are Moore (state-decoded) except BRANCH PC_Write and MEM_WAIT exit, which depend on current inputs.
REQ-034 PC_Write, IR_Write, Reg_Write, mem_rd, mem_wr never high outside states listed above; mem_rd and mem_wr never high together.

Reset
REQ-035 rst_n low forces IDLE immediately; all outputs 0, state=0, counter=0, illegal=0.
REQ-036 Reset during MEM_WAIT drops mem_rd/mem_wr asynchronously; no write-back occurs.

Configuration
REQ-037 Macro MCYC_BRANCH_EN: defined -> BRANCH state, pc_s logic present; undefined -> opcode 1100011 -> TRAP, pc_s tied 0.

Structure
REQ-038 Shared package mcyc_pkg: state enum, opcode constants, ALU_OP codes (ADD=0000, SUB=1000), w_data_s codes.
REQ-039 One sub-module: mcyc_wait_cnt (MEM_WAIT counter with clear, enable, limit compare).

Verification
REQ-040 add x3,x1,x2 (opcode 0110011, funct3 000, funct7 0) -> FETCH, DECODE, EXEC_R (ALU_OP=0000), WB_ALU Reg_Write=1; 4 cycles total.
REQ-041 lw with mem_ack on 3rd MEM_WAIT cycle -> mem_rd high 3 cycles, WB_LD Reg_Write=1 w_data_s=2; no ack for 15 cycles -> TRAP, illegal=1.
REQ-042 beq with zf=1 -> PC_Write=1, pc_s=1 in BRANCH; zf=0 -> PC_Write=0.
REQ-043 opcode 1111111 -> TRAP after DECODE, all enables 0 for 20 cycles.
REQ-044 rst_n low mid MEM_WAIT of sw -> mem_wr=0 before next edge, state=IDLE, then FETCH.
REQ-045 MCYC_BRANCH_EN undefined, beq -> TRAP.
